// File: rtl/cordic_pkg.sv
// cordic_pkg: shared state encoding and widths for the CORDIC iteration sequencer
package cordic_pkg;
  localparam int ITERS_DEF = 21;
  localparam int FP_W      = 32;
  localparam int SH_W      = 5;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_WAIT, S_DONE} state_t;
endpackage

// File: rtl/cordic_wdog.sv
// cordic_wdog: loadable cycle counter with clear/enable and a terminal-count flag
module cordic_wdog #(
  parameter int W  = 8,
  parameter int TC = 254
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic         en,
  input  logic [W-1:0] ld_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(TC);
endmodule

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: steps CORDIC micro-rotations through the arctan table and the
// rotate datapath, one valid/ready request per iteration, guarded by a watchdog.
module cordic_seq_ctrl
  import cordic_pkg::*;
#(
  parameter int ITERS   = ITERS_DEF,
  parameter int IDX_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             z_sign,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [FP_W-1:0]  tbl_data,
  output logic             load,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [FP_W-1:0]  op_angle,
  output logic             op_dir,
  output logic [SH_W-1:0]  op_shift,
  input  logic             op_done,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(ITERS - 1);
  state_t           state;
  logic [IDX_W-1:0] iter;
  logic             wd_tc;
  logic             xfer;
  assign xfer = state == S_ISSUE && op_ready;
  // The count sits at TIMEOUT-1 during the TIMEOUT-th WAIT cycle, which is the last one allowed.
  cordic_wdog #(.W(WD_W), .TC(TIMEOUT - 1)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == S_IDLE),
    .ld     (xfer),
    .en     (state == S_WAIT),
    .ld_val ('0),
    .tc     (wd_tc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= S_IDLE;
      iter     <= '0;
      op_angle <= '0;
      op_dir   <= 1'b0;
      op_shift <= '0;
      err      <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      iter  <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_LOAD;
            err   <= 1'b0;
          end
        S_LOAD: state <= S_FETCH;
        S_FETCH: begin
          op_angle <= tbl_data;
          op_dir   <= ~z_sign;
          op_shift <= iter[SH_W-1:0];
          state    <= S_ISSUE;
        end
        S_ISSUE: if (op_ready) state <= S_WAIT;
        S_WAIT:
          if (op_done) begin
            if (iter == LAST) state <= S_DONE;
            else begin
              iter  <= iter + 1'b1;
              state <= S_FETCH;
            end
          end else if (wd_tc) begin
            state <= S_IDLE;
            iter  <= '0;
            err   <= 1'b1;
          end
        S_DONE: begin
          state <= S_IDLE;
          iter  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  assign tbl_idx  = iter;
  assign load     = state == S_LOAD;
  assign op_valid = state == S_ISSUE;
  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;
endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// tb_cordic_seq_ctrl: randomized runs against a timeline model of each computation
module tb_cordic_seq_ctrl;
  localparam int ITERS = 21, TIMEOUT = 255, N = 1024;
  logic clk = 0, reset = 1, start = 0, abort = 0, z_sign = 0, op_ready = 0, op_done = 0;
  logic [7:0] tbl_idx;
  logic [31:0] tbl_data, op_angle;
  logic load, op_valid, op_dir, busy, done, err;
  logic [4:0] op_shift;
  logic [31:0] tbl [ITERS];
  int rd [ITERS], dd [ITERS];
  bit zp [ITERS];
  bit e_busy [N], e_load [N], e_valid [N], e_done [N], e_dir [N];
  logic [4:0] e_shift [N];
  logic [7:0] e_idx [N];
  logic [31:0] e_angle [N];
  bit d_rdy [N], d_dn [N], d_z [N], d_ab [N];
  int run_len, total = 0, bad = 0, mode = 0, cur = 0, busy_cnt, done_at, xfers;
  bit exp_err, idle_err = 0;
  logic [31:0] first_angle;
  logic [3:0] dir_seen;

  assign tbl_data = (tbl_idx < ITERS) ? tbl[tbl_idx] : 32'h0;

  cordic_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .z_sign(z_sign),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data), .load(load), .op_valid(op_valid),
    .op_ready(op_ready), .op_angle(op_angle), .op_dir(op_dir), .op_shift(op_shift),
    .op_done(op_done), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  // Lays out the cycle-by-cycle timeline of one run, offset 0 being the LOAD cycle.
  task automatic plan(input int ab);
    int o;
    bit ended;
    for (int i = 0; i < N; i++) begin
      e_busy[i] = 0; e_load[i] = 0; e_valid[i] = 0; e_done[i] = 0; e_dir[i] = 0;
      e_shift[i] = 0; e_idx[i] = 0; e_angle[i] = 0;
      d_rdy[i] = 1'($urandom); d_dn[i] = 1'($urandom); d_z[i] = 1'($urandom); d_ab[i] = 0;
    end
    e_load[0] = 1; e_busy[0] = 1; o = 1; exp_err = 0; ended = 0;
    for (int k = 0; k < ITERS && !ended; k++) begin
      e_busy[o] = 1; e_idx[o] = 8'(k); d_z[o] = zp[k]; o++;
      for (int j = 0; j <= rd[k]; j++) begin
        e_busy[o] = 1; e_idx[o] = 8'(k); e_valid[o] = 1; e_shift[o] = 5'(k);
        e_angle[o] = tbl[k]; e_dir[o] = ~zp[k]; d_rdy[o] = (j == rd[k]); o++;
      end
      if (dd[k] < 0) begin
        for (int j = 0; j < TIMEOUT; j++) begin
          e_busy[o] = 1; e_idx[o] = 8'(k); d_dn[o] = 0; o++;
        end
        exp_err = 1; ended = 1;
      end else begin
        for (int j = 0; j <= dd[k]; j++) begin
          e_busy[o] = 1; e_idx[o] = 8'(k); d_dn[o] = (j == dd[k]); o++;
        end
      end
    end
    if (!ended) begin
      e_busy[o] = 1; e_done[o] = 1; e_idx[o] = 8'(ITERS - 1); o++;
    end
    run_len = o;
    if (ab >= 0 && ab < run_len) begin
      d_ab[ab] = 1; run_len = ab + 1; exp_err = 0;
    end
  endtask

  task automatic set_nom();
    for (int k = 0; k < ITERS; k++) begin
      rd[k] = 0; dd[k] = 0; zp[k] = 1'($urandom);
    end
  endtask

  task automatic gap();
    mode = 2; start = 0; abort = 0; op_ready = 1'($urandom); op_done = 1'($urandom);
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 1'($urandom);
    @(posedge clk); #1;
    abort = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_load"}, load, 0);
    chk({tag, "_valid"}, op_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_idx"}, tbl_idx, 0);
    chk({tag, "_angle"}, op_angle, 0);
    chk({tag, "_dir"}, op_dir, 0);
    chk({tag, "_shift"}, op_shift, 0);
  endtask

  task automatic do_run(input int ab, input int rst_at);
    plan(ab);
    busy_cnt = 0; done_at = -1; xfers = 0; first_angle = 'x; dir_seen = 'x;
    mode = 2; start = 1; abort = 0; op_ready = 1'($urandom); op_done = 1'($urandom);
    z_sign = 1'($urandom);
    @(posedge clk); #1;
    for (int o = 0; o < run_len; o++) begin
      cur = o; mode = 1; start = 1'($urandom); abort = d_ab[o];
      op_ready = d_rdy[o]; op_done = d_dn[o]; z_sign = d_z[o];
      if (o == rst_at) begin
        mode = 0;
        #3 reset = 1;
        #1 chk_reset_vals("midrst");
        #2 reset = 0;
        idle_err = 0; start = 0; abort = 0;
        @(posedge clk); #1;
        mode = 2;
        return;
      end
      @(posedge clk); #1;
    end
    idle_err = exp_err; mode = 2; start = 0; abort = 0;
  endtask

  always @(negedge clk) begin
    if (mode == 1) begin
      chk("busy", busy, e_busy[cur]);
      chk("load", load, e_load[cur]);
      chk("op_valid", op_valid, e_valid[cur]);
      chk("done", done, e_done[cur]);
      chk("err_run", err, 0);
      chk("tbl_idx", tbl_idx, e_idx[cur]);
      if (e_valid[cur]) begin
        chk("op_angle", op_angle, e_angle[cur]);
        chk("op_dir", op_dir, e_dir[cur]);
        chk("op_shift", op_shift, e_shift[cur]);
      end
      if (busy) busy_cnt++;
      if (done) done_at = cur;
      if (op_valid && op_ready && !abort) xfers++;
      if (op_valid && op_shift < 4) dir_seen[op_shift[1:0]] = op_dir;
      if (op_valid && op_shift == 0) first_angle = op_angle;
    end else if (mode == 2) begin
      chk("idle_busy", busy, 0);
      chk("idle_load", load, 0);
      chk("idle_valid", op_valid, 0);
      chk("idle_done", done, 0);
      chk("idle_err", err, idle_err);
      chk("idle_idx", tbl_idx, 0);
    end
  end

  initial begin
    for (int i = 0; i < ITERS; i++) tbl[i] = (i == 0) ? 32'h42340000 : $urandom;
    repeat (2) @(posedge clk);
    #1 chk_reset_vals("rst");
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    gap();
    set_nom(); do_run(-1, -1);
    chk("nom_done_at", done_at, 64);
    chk("nom_busy_cycles", busy_cnt, 65);
    chk("nom_xfers", xfers, 21);
    chk("nom_angle0", first_angle, 32'h42340000);
    gap();
    set_nom(); rd[3] = 4; do_run(-1, -1);
    chk("bp_done_at", done_at, 68);
    chk("bp_xfers", xfers, 21);
    gap();
    set_nom();
    for (int k = 0; k < ITERS; k++) zp[k] = (k % 4 == 1) || (k % 4 == 2);
    do_run(-1, -1);
    chk("dir_pattern", dir_seen, 4'b1001);
    gap();
    set_nom(); dd[5] = -1; do_run(-1, -1);
    chk("wd_busy_cycles", busy_cnt, 273);
    chk("wd_no_done", done_at, -1);
    chk("wd_xfers", xfers, 6);
    chk("wd_err", err, 1);
    gap();
    set_nom(); do_run(-1, -1);
    chk("clr_err", err, 0);
    chk("clr_done_at", done_at, 64);
    gap();
    set_nom(); do_run(8, -1);
    chk("abort_busy_cycles", busy_cnt, 9);
    chk("abort_no_done", done_at, -1);
    chk("abort_xfers", xfers, 2);
    gap();
    set_nom(); do_run(-1, 33);
    gap();
    set_nom(); do_run(-1, -1);
    chk("post_rst_done_at", done_at, 64);
    chk("post_rst_xfers", xfers, 21);
    gap();
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < ITERS; k++) begin
        rd[k] = $urandom_range(0, 3); dd[k] = $urandom_range(0, 3); zp[k] = 1'($urandom);
      end
      if ($urandom_range(0, 9) == 0) dd[$urandom_range(0, ITERS - 1)] = -1;
      for (int i = 1; i < ITERS; i++) tbl[i] = $urandom;
      do_run(($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 150)) : -1, -1);
      gap();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cordic_seq_ctrl.md
# cordic_seq_ctrl

Iteration sequencer for the CORDIC sin(x) engine. Steps the micro-rotation index, addresses the arctan lookup table (IEEE-754 single-precision angles, in degrees), captures each table entry and the rotation direction, and issues one micro-rotation per iteration to the floating-point rotate datapath over a valid/ready handshake. Sits between the top-level start/done interface and the table + datapath pair, and guards every datapath operation with a watchdog.

## Interface
- ITERS, 21: number of micro-rotations; valid table indices 0..ITERS-1.
- IDX_W, 8: width of the table index.
- TIMEOUT, 255: max cycles spent in WAIT before the error abort.

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request a computation; accepted only in IDLE
- abort  in  1  cancel current computation
- z_sign  in  1  sign of datapath residual angle z (1 = negative)
- tbl_idx  out  IDX_W  arctan table index (= current iteration)
- tbl_data  in  32  arctan[tbl_idx], combinational from table
- load  out  1  one-cycle pulse: datapath loads x0, y0, z0
- op_valid  out  1  micro-rotation request
- op_ready  in  1  datapath accepts request
- op_angle  out  32  captured arctan value for this iteration
- op_dir  out  1  1 = rotate positive (z -= angle), 0 = negative
- op_shift  out  5  shift amount = iteration index
- op_done  in  1  datapath finished the accepted micro-rotation
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky watchdog error flag

## Operation
- States: IDLE, LOAD, FETCH, ISSUE, WAIT, DONE.
- IDLE: iter=0. start=1 -> LOAD; clear err.
- LOAD: load=1 for exactly this cycle -> FETCH.
- FETCH: tbl_idx=iter; capture op_angle<=tbl_data, op_dir<=~z_sign, op_shift<=iter -> ISSUE.
- ISSUE: op_valid=1, op_angle/op_dir/op_shift held stable until op_valid&op_ready; on transfer -> WAIT, clear watchdog.
- WAIT: op_done=1 -> if iter==ITERS-1 then DONE else iter<=iter+1, FETCH. Watchdog increments each WAIT cycle; count reaching TIMEOUT without op_done -> IDLE, err<=1.
- DONE: done=1 -> IDLE.
- op_done is ignored outside WAIT; op_ready is ignored outside ISSUE.
- start outside IDLE is ignored (no queuing).
- abort in any non-IDLE state -> IDLE next cycle, no done, err unchanged; op_valid drops even mid-handshake. abort and start together in IDLE: abort wins, stay IDLE.
- iter is IDX_W wide, never exceeds ITERS-1, no wrap. op_shift = iter[4:0].

## Timing
- Reset values: state IDLE, iter 0, tbl_idx 0, load 0, op_valid 0, op_angle 0, op_dir 0, op_shift 0, busy 0, done 0, err 0, watchdog 0.
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- z_sign is sampled in FETCH; datapath guarantees z is stable there (previous op complete or LOAD done).
- Per iteration, minimum 3 cycles (FETCH, ISSUE, WAIT) with op_ready=1 in ISSUE and op_done=1 in the first WAIT cycle.
- Best-case latency, ITERS=21: start sampled at edge 0, done high in cycle 65 (LOAD 1 + 63 + DONE 1).
- Reset mid-operation: immediate return to reset values; no done pulse.

## Structure
- cordic_pkg: state enum, ITERS default, FP_W=32, shift width 5.
- One sub-module, cordic_wdog: loadable cycle counter with clear/enable and terminal-count flag, used for the WAIT watchdog.
- Table and datapath are external; controller never writes the table.

## Test plan
- Nominal: start with op_ready=1 and op_done immediate -> 21 op_valid transfers with op_shift 0..20, op_angle equal to arctan[0..20] (entry 0 = 0x42340000), done at cycle 65, busy high cycles 1..65.
- Backpressure: op_ready low for 4 cycles on iteration 3 -> op_valid and fields held constant, no iteration skipped, done delayed by exactly 4 cycles.
- Direction: z_sign pattern 0,1,1,0,... -> op_dir = 1,0,0,1,... per iteration.
- Watchdog: op_done never asserted on iteration 5 -> IDLE after TIMEOUT WAIT cycles, err=1, no done; next start clears err.
- Abort in ISSUE, and start while busy -> IDLE next cycle with no done; the busy-time start is ignored with no extra run.
- Async reset asserted in WAIT of iteration 10 -> all outputs at reset values immediately; a fresh start runs the full 21 iterations.
